// File: rtl/sram_cmd_ctrl_if.sv
// Command byte stream and read-response stream of sram_cmd_ctrl.
// A byte moves on a rising clk edge where valid && ready are both high; once valid is raised the sender holds it and its data until that edge.
interface sram_cmd_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic [7:0]        cmd_data;
   logic              cmd_ready;
   logic              cmd_abort;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready;

   modport master (
      output cmd_valid, cmd_data, cmd_abort, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_abort, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sram_cmd_ctrl.sv
// Byte-serial framed read/write controller for a single-port SRAM macro.
// Frames: header {rw, 3'b0, len-1}, start address, then len data bytes for writes.
module sram_cmd_ctrl #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_cmd_ctrl_if.slave    bus,
   output logic              sram_csb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              busy,
   output logic              err,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_WRITE = 3'd3,
      S_RREQ  = 3'd4,
      S_RWAIT = 3'd5,
      S_RSEND = 3'd6
   } state_t;

   localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

   state_t            state, next_state;
   logic              rw_q;
   logic [3:0]        remaining_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        lat_cnt_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;

   logic cmd_fire, rsp_fire, hdr_ok, capture;
   logic csb_d, web_d, err_d, enter_access;

   assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
   assign rsp_fire  = rsp_valid_q && bus.rsp_ready;
   assign hdr_ok    = (bus.cmd_data[6:4] == 3'b000);
   assign capture   = (state == S_RWAIT) && (lat_cnt_q == 2'd0) && !bus.cmd_abort;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Abort overrides every transition, including a header handshaking this cycle.
   always_comb begin
      next_state = state;
      if (bus.cmd_abort) begin
         next_state = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (cmd_fire && hdr_ok) next_state = S_ADDR;
            S_ADDR:  if (cmd_fire) next_state = rw_q ? S_WDATA : S_RREQ;
            S_WDATA: if (cmd_fire) next_state = S_WRITE;
            S_WRITE: next_state = (remaining_q == 4'd0) ? S_IDLE : S_WDATA;
            S_RREQ:  next_state = S_RWAIT;
            S_RWAIT: if (lat_cnt_q == 2'd0) next_state = S_RSEND;
            S_RSEND: if (rsp_fire) next_state = (remaining_q == 4'd0) ? S_IDLE : S_RREQ;
            default: next_state = S_IDLE;
         endcase
      end
   end

   // Macro strobes are registered, so they are decoded from the state being entered.
   always_comb begin
      bus.cmd_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
      busy          = (state != S_IDLE);
      addr_d        = addr_q;
      if (state == S_ADDR && cmd_fire)
         addr_d = ADDR_W'(bus.cmd_data);
      else if (state == S_WRITE || (state == S_RSEND && rsp_fire))
         addr_d = addr_q + 1'b1;
      enter_access = (next_state == S_WRITE) || (next_state == S_RREQ);
      csb_d        = !enter_access;
      web_d        = (next_state != S_WRITE);
      err_d        = (state == S_IDLE) && cmd_fire && !hdr_ok && !bus.cmd_abort;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_q        <= 1'b0;
         remaining_q <= 4'd0;
         addr_q      <= '0;
         lat_cnt_q   <= 2'd0;
         sram_csb    <= 1'b1;
         sram_web    <= 1'b1;
         sram_addr   <= '0;
         sram_din    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         err         <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         sram_csb <= csb_d;
         sram_web <= web_d;
         err      <= err_d;
         if (enter_access) sram_addr <= addr_d;
         if (next_state == S_WRITE) sram_din <= DATA_W'(bus.cmd_data);

         if (state == S_IDLE && cmd_fire && hdr_ok) begin
            rw_q        <= bus.cmd_data[7];
            remaining_q <= bus.cmd_data[3:0];
         end else if ((state == S_WRITE || (state == S_RSEND && rsp_fire)) &&
                      remaining_q != 4'd0) begin
            remaining_q <= remaining_q - 1'b1;
         end

         if (state == S_RREQ)
            lat_cnt_q <= LAT_LOAD;
         else if (state == S_RWAIT && lat_cnt_q != 2'd0)
            lat_cnt_q <= lat_cnt_q - 1'b1;

         if (bus.cmd_abort) begin
            rsp_valid_q <= 1'b0;
         end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= sram_dout;
         end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// Bench for sram_cmd_ctrl: SRAM macro model, reference memory and expected
// write/read queues, directed scenarios followed by randomized frames.
module tb_sram_cmd_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_cmd_ctrl_if #(.DATA_W(8)) bus ();
   logic       sram_csb, sram_web, busy, err;
   logic [7:0] sram_addr, sram_din, sram_dout;
   logic [2:0] state_dbg;

   sram_cmd_ctrl #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .sram_csb  (sram_csb),
      .sram_web  (sram_web),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .busy      (busy),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // SRAM macro model: read data appears one edge after the sampling edge.
   logic [7:0] sram_mem [256];
   initial begin
      for (int i = 0; i < 256; i++) sram_mem[i] = 8'(i * 7 + 3);
      sram_dout = 8'h00;
      forever begin
         @(posedge clk);
         if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_addr] <= sram_din;
            else           sram_dout <= sram_mem[sram_addr];
         end
      end
   end

   // rsp_ready: 0 = held low, 1 = held high, 2 = random
   int rdy_mode = 1;
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      end
   end

   int         cyc = 0;
   int         rd_strobes = 0;
   logic [15:0] wr_obs_q[$];
   int          wr_cyc_q[$];
   logic [7:0]  rx_q[$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!sram_csb && !sram_web) begin
         wr_obs_q.push_back({sram_addr, sram_din});
         wr_cyc_q.push_back(cyc);
      end
      if (!sram_csb && sram_web) rd_strobes++;
      if (bus.rsp_valid && bus.rsp_ready) rx_q.push_back(bus.rsp_data);
   end

   // Reference model
   logic [7:0]  exp_mem [256];
   logic [15:0] exp_wr_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  wdata [16];

   int n_checks = 0;
   int n_pass = 0;
   int acc_cyc = 0;

   function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
      exp_mem[a] = d;
      exp_wr_q.push_back({a, d});
   endfunction

   function automatic void model_read(input logic [7:0] a);
      exp_q.push_back(exp_mem[a]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = b;
      while (!bus.cmd_ready && n < 200) begin
         tick();
         n++;
      end
      n_checks++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL send_byte: cmd_ready=%b for byte %h, want 1", bus.cmd_ready, b);
      else n_pass++;
      acc_cyc = cyc;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b, want 0", busy);
      else n_pass++;
   endtask

   task automatic write_frame(input logic [7:0] a, input int len);
      send_byte({1'b1, 3'b000, 4'(len - 1)});
      send_byte(a);
      for (int i = 0; i < len; i++) begin
         send_byte(wdata[i]);
         model_write(8'(a + i), wdata[i]);
      end
      wait_idle();
   endtask

   task automatic read_frame(input logic [7:0] a, input int len);
      send_byte({1'b0, 3'b000, 4'(len - 1)});
      send_byte(a);
      for (int i = 0; i < len; i++) model_read(8'(a + i));
      wait_idle();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({sram_csb, sram_web, sram_addr, sram_din, bus.rsp_valid, bus.rsp_data, busy, err} !==
          {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0})
         $display("FAIL reset_values: csb=%b web=%b addr=%h din=%h rv=%b rd=%h busy=%b err=%b",
                  sram_csb, sram_web, sram_addr, sram_din, bus.rsp_valid, bus.rsp_data, busy, err);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b want 1", bus.cmd_ready);
      else n_pass++;
   endtask

   task automatic test_single_word();
      int wb, rb, hdr, n;
      wb = wr_obs_q.size();
      send_byte(8'h80);
      hdr = acc_cyc;
      send_byte(8'h10);
      send_byte(8'hA5);
      model_write(8'h10, 8'hA5);
      n_checks++;
      if (bus.cmd_ready !== 1'b0) $display("FAIL single_write_ready_c3: cmd_ready=%b want 0", bus.cmd_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL single_write_ready_c4: cmd_ready=%b want 1", bus.cmd_ready);
      else n_pass++;
      n_checks++;
      if (wr_obs_q.size() - wb !== 1) $display("FAIL single_write_count: got %0d want 1", wr_obs_q.size() - wb);
      else n_pass++;
      if (wr_obs_q.size() > wb) begin
         n_checks++;
         if (wr_obs_q[wb] !== 16'h10A5) $display("FAIL single_write_access: got %h want 10a5", wr_obs_q[wb]);
         else n_pass++;
         n_checks++;
         if (wr_cyc_q[wb] !== hdr + 3) $display("FAIL single_write_latency: got %0d want %0d", wr_cyc_q[wb] - hdr, 3);
         else n_pass++;
      end

      rb = rx_q.size();
      send_byte(8'h00);
      hdr = acc_cyc;
      send_byte(8'h10);
      model_read(8'h10);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      n_checks++;
      if (cyc - hdr !== 4) $display("FAIL single_read_latency: got %0d want 4", cyc - hdr);
      else n_pass++;
      n_checks++;
      if (bus.rsp_data !== 8'hA5) $display("FAIL single_read_data: got %h want a5", bus.rsp_data);
      else n_pass++;
      wait_idle();
      n_checks++;
      if (rx_q.size() - rb !== 1) $display("FAIL single_read_count: got %0d want 1", rx_q.size() - rb);
      else n_pass++;
   endtask

   task automatic test_burst_wrap();
      int wb, rb;
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) wdata[i] = vals[i];
      wb = wr_obs_q.size();
      write_frame(8'hFE, 4);
      n_checks++;
      if (wr_obs_q.size() - wb !== 4) $display("FAIL burst_write_count: got %0d want 4", wr_obs_q.size() - wb);
      else n_pass++;
      if (wr_obs_q.size() - wb == 4) begin
         n_checks++;
         if (wr_obs_q[wb+2] !== 16'h0033) $display("FAIL burst_write_wrap: got %h want 0033", wr_obs_q[wb+2]);
         else n_pass++;
      end
      rb = rx_q.size();
      read_frame(8'hFE, 4);
      n_checks++;
      if (rx_q.size() - rb !== 4) $display("FAIL burst_read_count: got %0d want 4", rx_q.size() - rb);
      else n_pass++;
      for (int i = 0; i < 4 && rb + i < rx_q.size(); i++) begin
         n_checks++;
         if (rx_q[rb+i] !== vals[i]) $display("FAIL burst_read_data[%0d]: got %h want %h", i, rx_q[rb+i], vals[i]);
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL burst_busy_end: busy=%b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int rb, r0, n;
      logic [7:0] d0;
      rdy_mode = 0;
      tick();
      rb = rx_q.size();
      send_byte(8'h03);
      send_byte(8'hFE);
      for (int i = 0; i < 4; i++) model_read(8'(8'hFE + i));
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      d0 = bus.rsp_data;
      r0 = rd_strobes;
      n_checks++;
      if (d0 !== 8'h11) $display("FAIL bp_first_data: got %h want 11", d0);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0)
            $display("FAIL bp_hold[%0d]: valid=%b data=%h want valid=1 data=%h", i, bus.rsp_valid, bus.rsp_data, d0);
         else n_pass++;
         n_checks++;
         if (bus.cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, bus.cmd_ready);
         else n_pass++;
         n_checks++;
         if (rd_strobes !== r0) $display("FAIL bp_no_strobe[%0d]: got %0d want %0d", i, rd_strobes, r0);
         else n_pass++;
      end
      rdy_mode = 1;
      wait_idle();
      n_checks++;
      if (rx_q.size() - rb !== 4) $display("FAIL bp_count: got %0d want 4", rx_q.size() - rb);
      else n_pass++;
   endtask

   task automatic test_bad_header();
      int wb, r0;
      wb = wr_obs_q.size();
      r0 = rd_strobes;
      send_byte(8'h90);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) $display("FAIL bad_hdr_err: err=%b busy=%b want err=1 busy=0", err, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (err !== 1'b0) $display("FAIL bad_hdr_err_width: err=%b want 0", err);
      else n_pass++;
      n_checks++;
      if (wr_obs_q.size() != wb || rd_strobes != r0)
         $display("FAIL bad_hdr_no_access: writes=%0d reads=%0d want 0 0", wr_obs_q.size() - wb, rd_strobes - r0);
      else n_pass++;
      wdata[0] = 8'h5A;
      write_frame(8'h01, 1);
      n_checks++;
      if (wr_obs_q.size() != wb + 1 || wr_obs_q[wr_obs_q.size()-1] !== 16'h015A)
         $display("FAIL bad_hdr_recover: count=%0d last=%h want 1 015a", wr_obs_q.size() - wb, wr_obs_q[wr_obs_q.size()-1]);
      else n_pass++;
   endtask

   task automatic test_abort();
      int wb, rb;
      for (int i = 0; i < 4; i++) wdata[i] = 8'($urandom_range(0, 255));
      wb = wr_obs_q.size();
      send_byte(8'h83);
      send_byte(8'h40);
      for (int i = 0; i < 2; i++) begin
         send_byte(wdata[i]);
         model_write(8'(8'h40 + i), wdata[i]);
      end
      tick();
      bus.cmd_abort = 1'b1;
      tick();
      bus.cmd_abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0) $display("FAIL abort_idle: busy=%b err=%b want 0 0", busy, err);
      else n_pass++;
      repeat (2) tick();
      n_checks++;
      if (wr_obs_q.size() - wb !== 2) $display("FAIL abort_write_count: got %0d want 2", wr_obs_q.size() - wb);
      else n_pass++;
      rb = rx_q.size();
      read_frame(8'h40, 4);
      n_checks++;
      if (rx_q.size() - rb !== 4) $display("FAIL abort_followup_read: got %0d words want 4", rx_q.size() - rb);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int wb, r0, rb;
      rdy_mode = 1;
      rb = rx_q.size();
      send_byte(8'h00);
      send_byte(8'h10);
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sram_csb, sram_web, sram_addr, sram_din, bus.rsp_valid, bus.rsp_data, busy, err} !==
          {1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0})
         $display("FAIL mid_reset_values: csb=%b web=%b addr=%h din=%h rv=%b rd=%h busy=%b err=%b",
                  sram_csb, sram_web, sram_addr, sram_din, bus.rsp_valid, bus.rsp_data, busy, err);
      else n_pass++;
      wb = wr_obs_q.size();
      r0 = rd_strobes;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (wr_obs_q.size() != wb || rd_strobes != r0 || rx_q.size() != rb)
         $display("FAIL mid_reset_quiet: writes=%0d reads=%0d rsp=%0d want 0 0 0",
                  wr_obs_q.size() - wb, rd_strobes - r0, rx_q.size() - rb);
      else n_pass++;
      read_frame(8'h10, 1);
      n_checks++;
      if (rx_q.size() != rb + 1 || rx_q[rx_q.size()-1] !== 8'hA5)
         $display("FAIL mid_reset_readback: count=%0d data=%h want 1 a5", rx_q.size() - rb, rx_q[rx_q.size()-1]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] a;
      int len;
      rdy_mode = 2;
      for (int f = 0; f < 24; f++) begin
         a   = 8'($urandom_range(0, 255));
         len = $urandom_range(1, 16);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < len; i++) wdata[i] = 8'($urandom_range(0, 255));
            write_frame(a, len);
         end else begin
            read_frame(a, len);
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      rdy_mode = 1;
   endtask

   task automatic test_scoreboard();
      n_checks++;
      if (wr_obs_q.size() !== exp_wr_q.size())
         $display("FAIL sb_write_count: got %0d want %0d", wr_obs_q.size(), exp_wr_q.size());
      else n_pass++;
      for (int i = 0; i < wr_obs_q.size() && i < exp_wr_q.size(); i++) begin
         n_checks++;
         if (wr_obs_q[i] !== exp_wr_q[i]) $display("FAIL sb_write[%0d]: got %h want %h", i, wr_obs_q[i], exp_wr_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (rx_q.size() !== exp_q.size()) $display("FAIL sb_read_count: got %0d want %0d", rx_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL sb_read[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      bus.cmd_abort = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
      test_reset();
      test_single_word();
      test_burst_wrap();
      test_backpressure();
      test_bad_header();
      test_abort();
      test_reset_mid();
      test_random();
      test_scoreboard();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/sram_cmd_ctrl.md
Name: sram_cmd_ctrl

Overview:
- Byte-serial command controller sequencing the single-port SRAM macro inside tt_um_kmakise_sram.
- Accepts framed read/write commands on a valid/ready byte stream (fed from ui_in/uio_in by the top level).
- Drives the macro's active-low chip-select and write-enable, address and data.
- Returns read bytes on a valid/ready response stream (to uo_out).

Parameters:
- ADDR_W, 8, SRAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, SRAM word width; must equal the command byte width (8).
- READ_LAT, 1, cycles from the clock edge sampling a read to the edge on which sram_dout is valid for capture (1..4).

Ports:
- clk  in  1  clock; SRAM macro clocked on the same edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command byte valid.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  controller accepts cmd_data this cycle.
- cmd_abort  in  1  synchronous frame abort.
- rsp_valid  out  1  read byte valid.
- rsp_data  out  DATA_W  read byte.
- rsp_ready  in  1  consumer accepts rsp_data.
- sram_csb  out  1  macro chip select, active low.
- sram_web  out  1  macro write enable, active low.
- sram_addr  out  ADDR_W  macro address.
- sram_din  out  DATA_W  macro write data.
- sram_dout  in  DATA_W  macro read data.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle pulse on a rejected header.

Behaviour:
- Frame format:
  - byte0 is the header: [7]=1 write / 0 read; [6:4] reserved, must be 0; [3:0] = burst length-1, giving 1..16 words.
  - byte1 is the start address; the low ADDR_W bits are used.
  - Write frames carry length data bytes after byte1. Read frames end at byte1.
- Byte transfer: a byte transfers when cmd_valid && cmd_ready.
- cmd_ready is high only in IDLE, ADDR and WDATA.
- rsp_valid is registered. Once high, it and rsp_data hold until rsp_ready.
- States:
  - IDLE: on header accept, if reserved bits are nonzero, pulse err next cycle and stay in IDLE. Otherwise latch rw and remaining=len-1, then go to ADDR.
  - ADDR: on accept, load the address register. Write goes to WDATA; read goes to RREQ.
  - WDATA: on accept, latch the byte, then go to WRITE.
  - WRITE: exactly one cycle with sram_csb=0, sram_web=0, sram_addr=addr, sram_din=byte. Then addr <= addr+1 (wrap). If remaining==0 go to IDLE; else decrement remaining and go to WDATA.
  - RREQ: exactly one cycle with sram_csb=0, sram_web=1, sram_addr=addr. Then go to RWAIT.
  - RWAIT: READ_LAT cycles with csb=1. On the last edge, capture sram_dout into rsp_data and set rsp_valid, then go to RSEND.
  - RSEND: hold until rsp_ready. On handshake clear rsp_valid and set addr <= addr+1. If remaining==0 go to IDLE; else decrement and go to RREQ.
- sram_csb and sram_web are registered outputs: high in every state except WRITE/RREQ as above. sram_addr/sram_din hold their last values otherwise.
- Latency, single-word write: header c0, addr c1, data c2, macro write in c3, cmd_ready high again in c4.
- Latency, single-word read (READ_LAT=1): header c0, addr c1, RREQ in c2, capture at end of c3, rsp_valid high in c4.
- cmd_abort:
  - Highest priority: next state is IDLE from any state; csb/web go to 1 next cycle; rsp_valid clears; err does not pulse.
  - A write strobe already in the WRITE cycle completes; an abort in that cycle prevents further words.
  - cmd_abort in the same cycle as a header handshake discards the header.
- Address 2^ADDR_W-1 followed by a further burst word wraps to 0.
- cmd_valid while cmd_ready=0 is ignored; no byte is consumed.
- Reset (async assert, state to IDLE): sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, rsp_valid=0, rsp_data=0, busy=0, err=0. cmd_ready=1 once rst_n is high.
- Reset mid-burst abandons the frame; no partial macro access is generated after reset asserts.

Test Plan:
- Write frame 0x80,0x10,0xA5 -> exactly one cycle with csb=0, web=0, addr=0x10, din=0xA5, three cycles after header accept. Read frame 0x00,0x10 -> rsp_data=0xA5 with rsp_valid four cycles after header.
- Burst write 0x83,0xFE,11,22,33,44 -> writes to addresses FE,FF,00,01 (wrap). Burst read 0x03,0xFE with rsp_ready held high -> 11,22,33,44 in order, then busy=0.
- Read burst with rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable, no new csb=0 cycle, cmd_ready=0. Release -> remaining words delivered.
- Header 0x90 -> err pulses one cycle, state stays IDLE, no SRAM access. Following valid frame 0x80,0x01,0x5A -> executes normally.
- cmd_abort during WDATA of a 4-word write after 2 words -> only 2 write strobes, busy=0 next cycle, next header accepted.
- rst_n asserted during RWAIT -> outputs go to reset values immediately. After release, read 0x00,0x10 -> returns the previously written 0xA5.
